// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-bit match/parity link.
// Used by the transmitter and by the receiving checker.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    // XOR-ed into the reduction so data ones plus the parity bit come out even
    localparam logic PARITY_EVEN = 1'b0;

    function automatic int unsigned frame_len(input int unsigned nbits);
        return nbits + 1;
    endfunction

endpackage

// File: rtl/serial_parity_tx.sv
// Serialises an NBITS word LSB first, followed by one even-parity beat,
// using val/rdy handshakes on both the word and the bit side.
module serial_parity_tx
    import serial_link_pkg::*;
#(
    parameter int unsigned NBITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_bit,
    output logic             out_sof,
    output logic             out_par
);

    localparam int unsigned CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    state_e           state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             par_q, par_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            par_q   <= par_d;
        end
    end

    // Next-state and beat outputs; a stall simply keeps every register as is
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        par_d   = par_q;
        in_rdy  = 1'b0;
        out_val = 1'b0;
        out_bit = 1'b0;
        out_sof = 1'b0;
        out_par = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    shreg_d = in_msg;
                    par_d   = (^in_msg) ^ PARITY_EVEN;
                    count_d = '0;
                    state_d = DATA;
                end
            end

            DATA: begin
                out_val = 1'b1;
                out_bit = shreg_q[0];
                out_sof = (count_q == '0);
                if (out_rdy) begin
                    shreg_d = shreg_q >> 1;
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = PARITY;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end

            PARITY: begin
                out_val = 1'b1;
                out_bit = par_q;
                out_par = 1'b1;
                // Accept the next word on the final beat so frames run back to back
                in_rdy  = out_rdy;
                if (out_rdy) begin
                    if (in_val) begin
                        shreg_d = in_msg;
                        par_d   = (^in_msg) ^ PARITY_EVEN;
                        count_d = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
